// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
// Runs CPU-configured scans of the board ADC over a byte-serial command link.
// For each enabled channel one command byte is sent and a two-byte reply is
// collected; the latest 10-bit sample per channel is held for the io bus.
//
// Ports
//   clk12MHz              system clock
//   resetq                asynchronous, active-low reset
//   cfg_wr/addr/data      config write port
//                           0: channel mask
//                           1: scan period (us)
//                           2: bit0 trigger, bit1 clear err_count
//                           3: fresh-flag clear mask
//   tx_byte/valid/ready   command byte stream to the UART transmitter
//   rx_byte/valid         reply byte strobe from the UART receiver
//   value1..value4        latest samples, channels 0..3
//   fresh                 per-channel "updated since last clear" flags
//   busy                  a scan is in progress
//   err_count             saturating count of reply timeouts
module adc_scan_scheduler #(
   parameter logic [7:0]  CMD_BASE          = 8'hA1,
   parameter int          PRESCALE          = 12,
   parameter logic [15:0] DEFAULT_PERIOD_US = 16'd1000,
   parameter int          TIMEOUT_CYCLES    = 120000
) (
   input  logic        clk12MHz,
   input  logic        resetq,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [9:0]  value1,
   output logic [9:0]  value2,
   output logic [9:0]  value3,
   output logic [9:0]  value4,
   output logic [3:0]  fresh,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Returns {found, index} of the lowest set bit.
   function automatic logic [2:0] first_set(input logic [3:0] m);
      first_set = 3'b000;
      for (int i = 3; i >= 0; i--)
         if (m[i]) first_set = {1'b1, 2'(i)};
   endfunction

   state_t          state, state_nx;
   logic [PW-1:0]   presc;
   logic            tick;
   logic [15:0]     period, us_cnt;
   logic            timer_fire;
   logic [3:0]      mask, scan_mask;
   logic            pending;
   logic [1:0]      ch;
   logic [7:0]      hi;
   logic [TW-1:0]   tmo;
   logic [9:0]      val [4];
   logic            wr_mask, wr_period, wr_ctrl, wr_clr;
   logic            pend_take, ld_scan, step_ch, tx_fire, hi_cap, lo_cap, tmo_ev;
   logic            tmo_last;
   logic [2:0]      first_ch, next_ch;

   assign wr_mask   = cfg_wr & (cfg_addr == 2'd0);
   assign wr_period = cfg_wr & (cfg_addr == 2'd1);
   assign wr_ctrl   = cfg_wr & (cfg_addr == 2'd2);
   assign wr_clr    = cfg_wr & (cfg_addr == 2'd3);

   // Microsecond tick and scan period timer
   assign tick = (presc == PW'(PRESCALE - 1));

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) presc <= '0;
      else         presc <= tick ? '0 : presc + PW'(1);
   end

   // A period write restarts the count, so it also suppresses a coincident expiry.
   assign timer_fire = tick & (period != 16'd0) & (us_cnt == period - 16'd1) & ~wr_period;

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         period <= DEFAULT_PERIOD_US;
         us_cnt <= 16'd0;
      end else if (wr_period) begin
         period <= cfg_data;
         us_cnt <= 16'd0;
      end else if (tick && period != 16'd0) begin
         us_cnt <= (us_cnt == period - 16'd1) ? 16'd0 : us_cnt + 16'd1;
      end
   end

   // Scan request flag: a new request in the same cycle as consumption wins,
   // so it is never lost; repeated requests collapse into one.
   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         pending <= 1'b0;
         mask    <= 4'hF;
      end else begin
         pending <= (pending & ~pend_take) | timer_fire | (wr_ctrl & cfg_data[0]);
         if (wr_mask) mask <= cfg_data[3:0];
      end
   end

   // Scan sequencer
   assign first_ch = first_set(mask);
   assign next_ch  = first_set(scan_mask & (4'b1110 << ch));
   assign tmo_last = (tmo == TW'(1));

   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      pend_take = 1'b0;
      ld_scan   = 1'b0;
      step_ch   = 1'b0;
      tx_fire   = 1'b0;
      hi_cap    = 1'b0;
      lo_cap    = 1'b0;
      tmo_ev    = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               pend_take = 1'b1;
               if (mask != 4'h0) begin
                  ld_scan  = 1'b1;
                  state_nx = SEND;
               end
            end
         end
         SEND: begin
            if (tx_ready) begin
               tx_fire  = 1'b1;
               state_nx = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (rx_valid) begin
               hi_cap   = 1'b1;
               state_nx = WAIT_LO;
            end else if (tmo_last) begin
               tmo_ev   = 1'b1;
               state_nx = NEXT;
            end
         end
         WAIT_LO: begin
            if (rx_valid) begin
               lo_cap   = 1'b1;
               state_nx = NEXT;
            end else if (tmo_last) begin
               tmo_ev   = 1'b1;
               state_nx = NEXT;
            end
         end
         NEXT: begin
            if (next_ch[2]) begin
               step_ch  = 1'b1;
               state_nx = SEND;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-scan working registers; only meaningful while a scan runs.
   // tmo counts down the cycles left for the current reply byte; the wait
   // ends on the cycle where it would reach zero.
   always_ff @(posedge clk12MHz) begin
      if (ld_scan) begin
         scan_mask <= mask;
         ch        <= first_ch[1:0];
      end else if (step_ch) begin
         ch <= next_ch[1:0];
      end
      if (hi_cap) hi <= rx_byte;
      if (tx_fire || hi_cap)
         tmo <= TW'(TIMEOUT_CYCLES);
      else if (state == WAIT_HI || state == WAIT_LO)
         tmo <= tmo - TW'(1);
   end

   // Sample store, fresh flags and error count.
   // A capture and a clear of the same fresh bit in one cycle leaves it set;
   // an error-count clear beats a coincident increment.
   always_ff @(posedge clk12MHz or negedge resetq) begin
      if (!resetq) begin
         for (int i = 0; i < 4; i++) val[i] <= 10'd0;
         fresh     <= 4'h0;
         err_count <= 8'd0;
      end else begin
         if (lo_cap) val[ch] <= {hi[1:0], rx_byte};
         fresh <= (fresh & ~(wr_clr ? cfg_data[3:0] : 4'h0)) |
                  (lo_cap ? (4'b0001 << ch) : 4'h0);
         if (wr_ctrl && cfg_data[1])
            err_count <= 8'd0;
         else if (tmo_ev)
            err_count <= sat_inc(err_count);
      end
   end

   assign tx_valid = (state == SEND);
   assign tx_byte  = tx_valid ? CMD_BASE + {6'd0, ch} : 8'd0;
   assign busy     = (state != IDLE);
   assign value1   = val[0];
   assign value2   = val[1];
   assign value3   = val[2];
   assign value4   = val[3];

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the board ADC over its byte-serial command link, replacing free-running polling with a CPU-configured scan.
- Issues one command byte per enabled channel and collects the 2-byte reply.
- Holds the latest 10-bit value per channel.
- Sits between the J1 io bus (config writes, value/status reads) and a byte-level UART TX/RX pair.
- Handles period-driven and software-triggered scans, per-reply timeouts, and per-channel fresh flags.

Parameters:
CMD_BASE, 8'hA1, command byte for channel 0; channel n sends CMD_BASE+n.
PRESCALE, 12, clk12MHz cycles per microsecond tick.
DEFAULT_PERIOD_US, 16'd1000, reset value of the scan period register.
TIMEOUT_CYCLES, 120000, max cycles waited for each reply byte.

Ports:
clk12MHz  in  1  system clock
resetq  in  1  asynchronous, active-low reset
cfg_wr  in  1  config write strobe (one cycle per write)
cfg_addr  in  2  config register select
cfg_data  in  16  config write data
tx_byte  out  8  command byte to UART TX
tx_valid  out  1  command byte valid
tx_ready  in  1  UART TX accepts byte when tx_valid&tx_ready
rx_byte  in  8  byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_byte valid
value1..value4  out  10 each  latest sample, channels 0..3
fresh  out  4  bit n set when channel n updated since last clear
busy  out  1  scan in progress (state != IDLE)
err_count  out  8  reply-timeout count, saturating

Behaviour:
Reset (async, resetq=0):
- state IDLE, tx_valid=0, tx_byte=0.
- value1..4=0, fresh=0, err_count=0.
- mask=4'hF, period=DEFAULT_PERIOD_US, pending=0, us counter=0, tick prescaler=0.
- An in-flight transaction is abandoned. Bytes arriving after reset release are ignored because the FSM is in IDLE.

Config writes (cfg_wr):
- addr0: mask <= cfg_data[3:0].
- addr1: period <= cfg_data; the us counter also restarts at 0.
- addr2: bit0=1 sets pending (one-shot scan); bit1=1 clears err_count.
- addr3: fresh <= fresh & ~cfg_data[3:0].

Period timer:
- Prescaler produces a 1-cycle tick every PRESCALE cycles. The us counter increments on each tick.
- When the us counter reaches period-1 on a tick, it wraps to 0 and sets pending.
- period=0 disables the timer; scans then start only from addr2 triggers.
- pending is a single flag. Multiple requests while a scan runs collapse into one follow-up scan.

FSM states:
- IDLE:
  - If pending and mask!=0: clear pending, snapshot mask into scan_mask, set ch to the lowest set bit, go to SEND.
  - If pending and mask==0: clear pending, stay in IDLE.
- SEND: tx_valid=1 and tx_byte=CMD_BASE+ch, both stable until the handshake. On tx_valid&tx_ready go to WAIT_HI and load the timeout counter with TIMEOUT_CYCLES.
- WAIT_HI:
  - On rx_valid: hi <= rx_byte, reload the timeout counter, go to WAIT_LO.
  - On timeout reaching 0: err_count++ (saturate at 255), go to NEXT.
- WAIT_LO:
  - On rx_valid: value[ch] <= {hi[1:0], rx_byte}, fresh[ch] <= 1, go to NEXT.
  - On timeout: err_count++ (saturating), leave value unchanged, go to NEXT.
- NEXT (1 cycle): go to SEND on the next higher set bit of scan_mask; if none, go to IDLE.

Boundary rules:
- rx_valid in IDLE, SEND or NEXT is discarded.
- Mask writes during a scan affect the next scan only.
- Capture and an addr3 clear of the same bit in the same cycle: set wins, fresh bit = 1.
- err_count increment and a clear in the same cycle: clear wins, result 0.
- Writing addr1 does not disturb an active scan.

Latency:
- A trigger write at edge N sets pending at N. The FSM enters SEND at edge N+1, so tx_valid is high after N+1.
- Reply-to-value latency: value and fresh update on the edge that samples the second rx_valid.

Test Plan:
- Reset, period=0, mask=4'hF, write addr2=1 -> tx bytes A1,A2,A3,A4 in order. Replies (02,5A),(00,10),(03,FF),(01,00) give value1=0x25A, value2=0x010, value3=0x3FF, value4=0x100, fresh=4'hF, busy drops after last byte, err_count=0.
- mask=4'b1010, trigger -> only A2 and A4 sent; fresh=4'b1010. Write addr3=4'b0010 -> fresh=4'b1000. A capture of ch1 coincident with an addr3 clear of bit1 -> fresh[1]=1.
- Trigger, no reply to A1 -> after TIMEOUT_CYCLES in WAIT_HI, err_count=1 and A2 is sent. A reply of hi only for A2 -> timeout in WAIT_LO, value2 unchanged, err_count=2. Write addr2=2 -> err_count=0.
- period=3, mask=4'b0001, tx_ready tied 1, instant replies -> A1 sent every 36 cycles. Trigger plus a period expiry during a scan -> exactly one follow-up scan.
- tx_ready held 0 for 50 cycles in SEND -> tx_valid=1, tx_byte=A1 stable throughout. Stray rx_valid in IDLE -> no value or fresh change.
- resetq low while in WAIT_LO -> outputs return to reset values immediately. A late rx byte after release is ignored, and the next trigger restarts from channel 0.
